// File: rtl/enc_bundler_seq.sv
// Bit-wise bundler: accumulates N_HV bound hypervectors per beat over N_BEATS beats
// into per-dimension counters, then thresholds them into one bundled hypervector.
module enc_bundler_seq #(
    parameter int unsigned HV_DIM    = 1024,
    parameter int unsigned N_HV      = 10,
    parameter int unsigned N_BEATS   = 8,
    parameter int unsigned THRESHOLD = 4
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start_encoding,
    input  logic                               in_valid,
    input  logic [HV_DIM-1:0]                  shifted_hv [0:N_HV-1],
    output logic                               in_ready,
    output logic [$clog2(N_BEATS+1)-1:0]       beat_cnt,
    output logic [HV_DIM-1:0]                  bundled_hv,
    output logic                               out_valid,
    output logic                               busy
);

    localparam int unsigned CNT_W  = $clog2(N_HV * N_BEATS + 1);
    localparam int unsigned ADD_W  = $clog2(N_HV + 1);
    localparam int unsigned BEAT_W = $clog2(N_BEATS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_THRESH = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q [HV_DIM];
    logic [CNT_W-1:0]  cnt_d [HV_DIM];
    logic [BEAT_W-1:0] beat_q,      beat_d;
    logic [HV_DIM-1:0] bundled_q,   bundled_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q,  in_ready_d;
    logic              busy_q,      busy_d;

    logic [ADD_W-1:0]  pop   [HV_DIM];
    logic [CNT_W-1:0]  sat   [HV_DIM];
    logic [CNT_W:0]    sum   [HV_DIM];
    logic [HV_DIM-1:0] thresh;

    // Per-dimension popcount across the pack, saturating counter add, and threshold.
    always_comb begin
        for (int b = 0; b < HV_DIM; b++) begin
            pop[b] = '0;
            for (int i = 0; i < N_HV; i++) begin
                pop[b] = pop[b] + ADD_W'(shifted_hv[i][b]);
            end
            sum[b]    = {1'b0, cnt_q[b]} + (CNT_W+1)'(pop[b]);
            sat[b]    = sum[b][CNT_W] ? {CNT_W{1'b1}} : sum[b][CNT_W-1:0];
            thresh[b] = (cnt_q[b] >= CNT_W'(THRESHOLD));
        end
    end

    // Next-state and output logic; start_encoding always takes priority over a beat.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        bundled_d   = bundled_q;
        out_valid_d = 1'b0;

        if (start_encoding) begin
            state_d = ST_ACCUM;
            beat_d  = '0;
            for (int b = 0; b < HV_DIM; b++) begin
                cnt_d[b] = '0;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        cnt_d  = sat;
                        beat_d = beat_q + BEAT_W'(1);
                        if (beat_d == BEAT_W'(N_BEATS)) begin
                            state_d = ST_THRESH;
                        end
                    end
                end
                ST_THRESH: begin
                    bundled_d   = thresh;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        in_ready_d = (state_d == ST_ACCUM);
        busy_d     = (state_d == ST_ACCUM) || (state_d == ST_THRESH);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            bundled_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int b = 0; b < HV_DIM; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            bundled_q   <= bundled_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            for (int b = 0; b < HV_DIM; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign beat_cnt   = beat_q;
    assign bundled_hv = bundled_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/enc_bundler_seq.md
Name: enc_bundler_seq

Overview:
- Downstream of the enc_binder_pack_* stage. Consumes the ten shifted (bound) hypervectors each pack produces per beat.
- Accumulates them bit-wise over N_BEATS beats into per-dimension counters. Thresholds the counters into one sparse bundled HV.
- Hands the result to the classifier/similarity stage with a one-cycle valid pulse.

Parameters:
- HV_DIM, 1024, hypervector width in bits (matches the codebase-wide HV_DIM).
- N_HV, 10, bound HVs presented per beat (equals the binder pack width).
- N_BEATS, 8, beats (packs) accumulated per encoding.
- THRESHOLD, 4, minimum count for an output bit to be 1; legal range 1..N_HV*N_BEATS.
- CNT_W, $clog2(N_HV*N_BEATS+1), counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nrst  input  1  reset; synchronous, active-high (nrst=1 resets on the next clk edge).
- start_encoding  input  1  one-cycle pulse; clears counters and begins a new encoding.
- in_valid  input  1  shifted_hv holds a valid beat this cycle.
- shifted_hv  input  [HV_DIM-1:0] x [0:N_HV-1]  bound HVs from the binder pack.
- in_ready  output  1  high when a beat is accepted (state ACCUM).
- beat_cnt  output  [$clog2(N_BEATS+1)-1:0]  beats accepted in the current encoding.
- bundled_hv  output  [HV_DIM-1:0]  thresholded result.
- out_valid  output  1  one-cycle pulse when bundled_hv updates.
- busy  output  1  high in ACCUM or THRESH.

Behaviour:
- Reset (nrst=1 at an edge):
  - state goes to IDLE.
  - All counters, beat_cnt, bundled_hv and out_valid go to 0.
  - in_ready and busy go to 0.
  - Reset overrides every other input in the same cycle, including in the middle of an encoding.
- States are IDLE, ACCUM, THRESH, DONE.
- IDLE:
  - in_ready=0.
  - start_encoding moves to ACCUM, clears counters and clears beat_cnt.
- ACCUM:
  - in_ready=1.
  - On in_valid, for every bit b: cnt[b] <= cnt[b] + popcount over i of shifted_hv[i][b]. Each add is 0..N_HV.
  - beat_cnt increments on each accepted beat.
  - When the beat that makes beat_cnt reach N_BEATS is accepted, move to THRESH on the next edge.
  - Cycles without in_valid leave all state unchanged (no timeout).
- Counter arithmetic:
  - Unsigned and saturating at 2^CNT_W-1.
  - Saturation cannot occur with the derived CNT_W; it remains as a safety net for overridden widths.
- THRESH:
  - Lasts exactly one cycle with in_ready=0.
  - bundled_hv[b] <= (cnt[b] >= THRESHOLD).
  - out_valid <= 1 on the same edge that loads bundled_hv. Then move to DONE.
- DONE:
  - out_valid returns to 0 after one cycle.
  - bundled_hv holds until the next THRESH.
  - start_encoding moves to ACCUM.
- Latency: last beat accepted at edge t; bundled_hv and out_valid are visible after edge t+1.
- start_encoding asserted in ACCUM or THRESH:
  - Aborts the encoding, clears counters and beat_cnt, re-enters ACCUM.
  - No out_valid is produced for the aborted encoding.
  - bundled_hv keeps its previous value.
- start_encoding together with in_valid in the same cycle: start wins and the beat is dropped (not counted).
- in_valid in IDLE, THRESH or DONE is ignored.
- busy = (state==ACCUM) or (state==THRESH).
- X on shifted_hv while in_valid=0 must not propagate into the counters.

Test Plan (HV_DIM=16, N_HV=10, N_BEATS=2, THRESHOLD=4 unless noted):
- Reset → outputs 0: hold nrst=1 for 2 cycles with in_valid=1 → bundled_hv=0, out_valid=0, in_ready=0, busy=0, beat_cnt=0.
- Basic bundle and threshold: start; beat0 all ten HVs=16'h000F; beat1 HVs 0..3=16'h00F0, rest 0 → counts are bits0-3=10 and bits4-7=4, so bundled_hv=16'h00FF with out_valid high exactly one cycle, one cycle after beat1.
- Threshold edge: THRESHOLD=5, same stimulus as the basic bundle → bundled_hv=16'h000F (count 4 rejected).
- Gaps and ignored input: in_valid deasserted for 5 cycles between beats, plus in_valid pulses in IDLE and DONE → same result as the basic bundle; beat_cnt=2 at completion.
- Abort and collision: after beat0, assert start_encoding together with in_valid (HV=16'hFFFF) → beat dropped, beat_cnt=0, no out_valid. Then two beats of all-zero HVs → bundled_hv=16'h0000.
- Mid-encoding reset: nrst=1 after beat0 → IDLE, beat_cnt=0. A following start plus two all-zero beats → bundled_hv=16'h0000.
